serializer: RTL and testbench
=============================

# serializer

Parallel-to-serial transmitter for the 100 kHz byte link. Takes one byte from the upstream queue with a valid/ack handshake and shifts it out MSB first, one bit per `write_out` strobe, only while the downstream receiver reports it is ready. It drives the bit-serial side that the link's deserializer consumes.

## Interface
- `DATA_WIDTH`, 8, number of bits per word; bit counter is `$clog2(DATA_WIDTH+1)` bits wide.
- `clock_100KHZ`  in  1  sole clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `data_in`  in  DATA_WIDTH  parallel word from the queue; sampled only on accept.
- `data_valid`  in  1  queue has a word on `data_in`.
- `ready_in`  in  1  receiver ready for a bit; connects to the receiver's `status_out`.
- `ack_out`  out  1  one-cycle pulse: word captured, queue may advance.
- `data_out`  out  1  serial bit, valid while `write_out`=1.
- `write_out`  out  1  bit strobe; one bit transferred per cycle it is high.
- `status_out`  out  1  1 while a word is being transmitted (SEND or DONE).
- `EA_ser`  out  2  current state encoding, for debug.

## Operation
- All outputs are registered. Internal state: `shreg` [DATA_WIDTH], `count`, `EA`.
- States: IDLE=2'd0, SEND=2'd1, DONE=2'd2. Code 2'd3 is illegal and returns to IDLE on the next edge with all outputs at 0.
- IDLE: `write_out`=0, `status_out`=0. If `data_valid`=1: `shreg`<=`data_in`, `count`<=0, `ack_out`<=1, `status_out`<=1, go to SEND. Otherwise stay.
- SEND: `ack_out`<=0 unconditionally.
  - If `ready_in`=1: `data_out`<=`shreg[DATA_WIDTH-1]`, `write_out`<=1, `shreg`<=`shreg`<<1, `count`<=`count`+1. If `count`==DATA_WIDTH-1, go to DONE.
  - If `ready_in`=0: `write_out`<=0, `data_out` holds, no shift, no count (stall).
- DONE: `write_out`<=0, `status_out`<=0, `data_out`<=0, go to IDLE. This gives a guaranteed one-cycle gap with no strobe between words.
- `data_valid` is ignored outside IDLE, and no `ack_out` is generated for it. Exactly one `ack_out` pulse per word.
- Bit order is MSB first. A shift-left receiver therefore reassembles the word unchanged.

## Timing
- Reset value of every output: `data_out`=0, `write_out`=0, `ack_out`=0, `status_out`=0, `EA_ser`=0. Internal `shreg`=0, `count`=0.
- Reset asserted mid-word: outputs drop immediately (asynchronous). The partial word is discarded and no ack is issued. After release, the block starts in IDLE.
- Accept at edge E0 (IDLE, `data_valid`=1):
  - `ack_out` is high for exactly the cycle after E0.
  - `status_out` rises after E0.
- With `ready_in` held at 1:
  - Bits are driven on edges E1..E8 (DATA_WIDTH=8), so `write_out` is high for 8 consecutive cycles.
  - DONE is entered at E8, and `write_out`/`status_out` fall at E9.
  - IDLE is reached at E9 and can accept at E10.
- Minimum spacing between accepts is DATA_WIDTH+2 cycles.
- Each stall cycle (`ready_in`=0 in SEND) adds exactly one cycle. There is no upper bound on stalls.
- `ready_in` is used only in SEND. `data_valid` and `ready_in` both high in IDLE results in a load only, with no bit driven that cycle.

## Test plan
- Reset: assert `reset` mid-simulation -> all outputs 0 and `EA_ser`=0 in the same cycle, held until release.
- Single word 8'hA5, `ready_in`=1 constant ->
  - one `ack_out` pulse one cycle after accept;
  - `write_out` high for 8 consecutive cycles with `data_out` = 1,0,1,0,0,1,0,1;
  - `status_out` falls 9 cycles after accept.
- Stall: 8'h3C, `ready_in` dropped for 3 cycles after the 3rd bit -> `write_out` low for those 3 cycles, `data_out` holds, full sequence still 0,0,1,1,1,1,0,0, total transfer 3 cycles longer.
- Back-to-back: `data_valid` held high with 8'hFF then 8'h00 presented after the first ack ->
  - exactly two `ack_out` pulses, 10 cycles apart;
  - at least one cycle with `write_out`=0 between words;
  - bits all 1s then all 0s.
- Reset mid-word: 8'hF0, `reset` after the 4th bit -> no further strobes; next word 8'h81 is sent from its MSB as 1,0,0,0,0,0,0,1.
- Loopback with a shift-left receiver model that drives `ready_in` and drops it after 8 bits until it is acked: 8'h5A -> receiver captures 8'h5A, and the block stays idle until the next `data_valid`.

Source files
------------

// File: rtl/serializer.sv
// Parallel-to-serial transmitter: accepts a word on valid/ack and shifts it out
// MSB first, one bit per write_out strobe, only while the receiver is ready.
module serializer #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clock_100KHZ,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid,
  input  logic                  ready_in,
  output logic                  ack_out,
  output logic                  data_out,
  output logic                  write_out,
  output logic                  status_out,
  output logic [1:0]            EA_ser
);

  localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    DONE    = 2'd2,
    ILLEGAL = 2'd3
  } state_e;

  state_e                ea_q, ea_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  ack_q, ack_d;
  logic                  data_q, data_d;
  logic                  write_q, write_d;
  logic                  status_q, status_d;

  // State and registered outputs
  always_ff @(posedge clock_100KHZ or posedge reset) begin
    if (reset) begin
      ea_q     <= IDLE;
      shreg_q  <= '0;
      count_q  <= '0;
      ack_q    <= 1'b0;
      data_q   <= 1'b0;
      write_q  <= 1'b0;
      status_q <= 1'b0;
    end else begin
      ea_q     <= ea_d;
      shreg_q  <= shreg_d;
      count_q  <= count_d;
      ack_q    <= ack_d;
      data_q   <= data_d;
      write_q  <= write_d;
      status_q <= status_d;
    end
  end

  // Next-state and output logic; ack and strobe are single-cycle by default
  always_comb begin
    ea_d     = ea_q;
    shreg_d  = shreg_q;
    count_d  = count_q;
    ack_d    = 1'b0;
    data_d   = data_q;
    write_d  = 1'b0;
    status_d = status_q;
    case (ea_q)
      IDLE: begin
        status_d = 1'b0;
        if (data_valid) begin
          shreg_d  = data_in;
          count_d  = '0;
          ack_d    = 1'b1;
          status_d = 1'b1;
          ea_d     = SEND;
        end
      end
      SEND: begin
        // A low ready_in stalls: data_out holds, no shift, no count
        if (ready_in) begin
          data_d  = shreg_q[DATA_WIDTH-1];
          write_d = 1'b1;
          shreg_d = shreg_q << 1;
          count_d = count_q + CNT_W'(1);
          if (count_q == LAST_BIT) begin
            ea_d = DONE;
          end
        end
      end
      DONE: begin
        status_d = 1'b0;
        data_d   = 1'b0;
        ea_d     = IDLE;
      end
      default: begin
        status_d = 1'b0;
        data_d   = 1'b0;
        ea_d     = IDLE;
      end
    endcase
  end

  assign ack_out    = ack_q;
  assign data_out   = data_q;
  assign write_out  = write_q;
  assign status_out = status_q;
  assign EA_ser     = 2'(ea_q);

endmodule

// File: tb/tb_serializer.sv
// Directed bench for serializer: expected serial bits are queued when a word is
// driven and popped by a monitor on every strobe.
module tb_serializer;

  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] data_in;
  logic          data_valid;
  logic          tb_ready;
  logic          rx_ready;
  logic          loop_mode;
  logic          ready_in;
  logic          ack_out, data_out, write_out, status_out;
  logic [1:0]    EA_ser;

  int   total = 0;
  int   bad   = 0;
  int   strobes = 0;
  logic exp_q[$];
  logic [DW-1:0] rx_word;
  int   rx_cnt;

  assign ready_in = loop_mode ? rx_ready : tb_ready;

  always #5 clk = ~clk;

  serializer #(.DATA_WIDTH(DW)) dut (
    .clock_100KHZ(clk),
    .reset       (reset),
    .data_in     (data_in),
    .data_valid  (data_valid),
    .ready_in    (ready_in),
    .ack_out     (ack_out),
    .data_out    (data_out),
    .write_out   (write_out),
    .status_out  (status_out),
    .EA_ser      (EA_ser)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    for (int i = DW - 1; i >= 0; i--) exp_q.push_back(w[i]);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every strobe must match the next queued bit
  always @(negedge clk) begin : mon
    logic e;
    if (!reset && write_out) begin
      strobes++;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
      chk("serial_bit", 32'(data_out), 32'(e));
    end
  end

  // Shift-left receiver: deasserts ready after a full word until acknowledged
  always @(negedge clk) begin
    if (loop_mode && !reset && write_out && rx_cnt < int'(DW)) begin
      rx_word = {rx_word[DW-2:0], data_out};
      rx_cnt++;
      if (rx_cnt == int'(DW)) rx_ready = 1'b0;
    end
  end

  initial begin
    int acks;
    int ack2_at;
    int gap;
    int s0;

    reset = 1'b1; data_valid = 1'b0; data_in = '0; tb_ready = 1'b1;
    loop_mode = 1'b0; rx_ready = 1'b1; rx_word = '0; rx_cnt = 0;
    repeat (2) tick();
    chk("reset_outputs", 32'({ack_out, data_out, write_out, status_out, EA_ser}), 32'd0);
    reset = 1'b0;
    tick();

    // Single word A5, ready held high
    push_word(8'hA5); data_in = 8'hA5; data_valid = 1'b1;
    tick(); data_valid = 1'b0;
    chk("a5_ack_pulse", 32'(ack_out), 32'd1);
    chk("a5_status_rise", 32'(status_out), 32'd1);
    chk("a5_load_only", 32'(write_out), 32'd0);
    chk("a5_state_send", 32'(EA_ser), 32'd1);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("a5_write_high", 32'(write_out), 32'd1);
      chk("a5_ack_low", 32'(ack_out), 32'd0);
    end
    chk("a5_state_done", 32'(EA_ser), 32'd2);
    chk("a5_status_held", 32'(status_out), 32'd1);
    tick();
    chk("a5_status_fall", 32'(status_out), 32'd0);
    chk("a5_write_fall", 32'(write_out), 32'd0);
    chk("a5_state_idle", 32'(EA_ser), 32'd0);
    chk("a5_queue_drained", 32'(exp_q.size()), 32'd0);

    // Word 3C with a 3-cycle stall after the third bit
    push_word(8'h3C); data_in = 8'h3C; data_valid = 1'b1;
    tick(); data_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_pre_write", 32'(write_out), 32'd1);
    end
    tb_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_write_low", 32'(write_out), 32'd0);
      chk("stall_data_hold", 32'(data_out), 32'd1);
      chk("stall_state", 32'(EA_ser), 32'd1);
    end
    tb_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_post_write", 32'(write_out), 32'd1);
    end
    chk("stall_done_late", 32'(EA_ser), 32'd2);
    tick();
    chk("stall_status_fall", 32'(status_out), 32'd0);
    chk("stall_queue_drained", 32'(exp_q.size()), 32'd0);

    // Back-to-back FF then 00 with data_valid held high
    push_word(8'hFF); data_in = 8'hFF; data_valid = 1'b1;
    tick();
    chk("b2b_first_ack", 32'(ack_out), 32'd1);
    push_word(8'h00); data_in = 8'h00;
    acks = 0; ack2_at = -1; gap = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (ack_out) begin
        acks++;
        ack2_at = i;
        data_valid = 1'b0;
      end
      if (i <= 10 && !write_out) gap++;
    end
    chk("b2b_extra_acks", 32'(acks), 32'd1);
    chk("b2b_ack_spacing", 32'(ack2_at), 32'd10);
    chk("b2b_gap_cycles", 32'(gap), 32'd2);
    chk("b2b_state_idle", 32'(EA_ser), 32'd0);
    chk("b2b_queue_drained", 32'(exp_q.size()), 32'd0);

    // Reset after the fourth bit of F0, then 81 from a clean start
    push_word(8'hF0); data_in = 8'hF0; data_valid = 1'b1;
    tick(); data_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rst_pre_write", 32'(write_out), 32'd1);
    end
    #2 reset = 1'b1;
    #1;
    chk("rst_async_outputs", 32'({ack_out, data_out, write_out, status_out, EA_ser}), 32'd0);
    exp_q.delete();
    s0 = strobes;
    repeat (2) tick();
    chk("rst_held_outputs", 32'({ack_out, data_out, write_out, status_out, EA_ser}), 32'd0);
    reset = 1'b0;
    repeat (3) tick();
    chk("rst_no_strobes", 32'(strobes - s0), 32'd0);
    chk("rst_idle", 32'(EA_ser), 32'd0);
    push_word(8'h81); data_in = 8'h81; data_valid = 1'b1;
    tick(); data_valid = 1'b0;
    chk("w81_ack", 32'(ack_out), 32'd1);
    repeat (9) tick();
    chk("w81_strobes", 32'(strobes - s0), 32'd8);
    chk("w81_idle", 32'(EA_ser), 32'd0);
    chk("w81_queue_drained", 32'(exp_q.size()), 32'd0);

    // Loopback into the shift-left receiver model
    rx_ready = 1'b1; rx_cnt = 0; rx_word = '0; loop_mode = 1'b1;
    push_word(8'h5A); data_in = 8'h5A; data_valid = 1'b1;
    tick(); data_valid = 1'b0;
    repeat (12) tick();
    chk("loop_rx_word", 32'(rx_word), 32'h5A);
    chk("loop_rx_count", 32'(rx_cnt), 32'd8);
    chk("loop_ready_dropped", 32'(ready_in), 32'd0);
    chk("loop_idle_state", 32'(EA_ser), 32'd0);
    chk("loop_idle_outputs", 32'({ack_out, write_out, status_out}), 32'd0);
    rx_ready = 1'b1;
    repeat (4) tick();
    chk("loop_stays_idle", 32'({ack_out, write_out, status_out, EA_ser}), 32'd0);
    chk("loop_queue_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
